// File: rtl/wb_stage.sv
// Writeback stage: selects the commit value, owns the scalar and vector register files,
// serves bypassed read ports to decode, keeps a one-cycle forwarding record and counts
// retired instructions.
module wb_stage #(
    parameter int unsigned REGI_BITS = 4,
    parameter int unsigned VECT_BITS = 2,
    parameter int unsigned REGI_SIZE = 16,
    parameter int unsigned SCAL_SIZE = 32,
    parameter int unsigned VECT_SIZE = 8,
    parameter int unsigned ELEM_SIZE = 8,
    localparam int unsigned VW = ELEM_SIZE * VECT_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enableReg_i,
    input  logic                 flagMemRead_i,
    input  logic                 writeResultInt_i,
    input  logic                 writeResultV_i,
    input  logic [VW-1:0]        int_rd_i,
    input  logic [VW-1:0]        alu_res_i,
    input  logic [REGI_BITS-1:0] dstS_i,
    input  logic [VECT_BITS-1:0] dstV_i,
    input  logic [REGI_BITS-1:0] rsA_i,
    input  logic [REGI_BITS-1:0] rsB_i,
    input  logic [VECT_BITS-1:0] rvA_i,
    input  logic [VECT_BITS-1:0] rvB_i,
    output logic [SCAL_SIZE-1:0] rdA_o,
    output logic [SCAL_SIZE-1:0] rdB_o,
    output logic [VW-1:0]        rvdA_o,
    output logic [VW-1:0]        rvdB_o,
    output logic                 fwdValidS_o,
    output logic                 fwdValidV_o,
    output logic [REGI_BITS-1:0] fwdDstS_o,
    output logic [VECT_BITS-1:0] fwdDstV_o,
    output logic [VW-1:0]        fwdData_o,
    output logic [31:0]          retired_o
);

    localparam int unsigned VREGS = 2 ** VECT_BITS;

    logic [SCAL_SIZE-1:0] rfS [REGI_SIZE];
    logic [VW-1:0]        rfV [VREGS];

    logic [VW-1:0]        wbVal;
    logic                 commitS;
    logic                 commitV;
    logic                 retire;

    logic                 fwdValidSQ;
    logic                 fwdValidVQ;
    logic [REGI_BITS-1:0] fwdDstSQ;
    logic [VECT_BITS-1:0] fwdDstVQ;
    logic [VW-1:0]        fwdDataQ;
    logic [31:0]          retiredQ;

    // Commit decode; reset suppresses commits (and therefore bypass) in its cycle.
    always_comb begin
        wbVal   = flagMemRead_i ? int_rd_i : alu_res_i;
        commitS = ~rst_i & enableReg_i & writeResultInt_i & (dstS_i != '0);
        commitV = ~rst_i & enableReg_i & writeResultV_i;
        // A dropped r0 write still retires.
        retire  = ~rst_i & enableReg_i & (writeResultInt_i | writeResultV_i);
    end

    // Scalar register file; entry 0 is never written so it stays zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(REGI_SIZE); i++) begin
                rfS[i] <= '0;
            end
        end else if (commitS) begin
            rfS[dstS_i] <= wbVal[SCAL_SIZE-1:0];
        end
    end

    // Vector register file.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(VREGS); i++) begin
                rfV[i] <= '0;
            end
        end else if (commitV) begin
            rfV[dstV_i] <= wbVal;
        end
    end

    // Scalar read ports with write-through bypass; r0 always reads zero.
    always_comb begin
        rdA_o = '0;
        rdB_o = '0;
        if (rsA_i != '0) begin
            rdA_o = (commitS && dstS_i == rsA_i) ? wbVal[SCAL_SIZE-1:0] : rfS[rsA_i];
        end
        if (rsB_i != '0) begin
            rdB_o = (commitS && dstS_i == rsB_i) ? wbVal[SCAL_SIZE-1:0] : rfS[rsB_i];
        end
    end

    // Vector read ports with write-through bypass.
    always_comb begin
        rvdA_o = (commitV && dstV_i == rvA_i) ? wbVal : rfV[rvA_i];
        rvdB_o = (commitV && dstV_i == rvB_i) ? wbVal : rfV[rvB_i];
    end

    // Forwarding record: valids track every edge, payload holds unless a commit fires.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwdValidSQ <= 1'b0;
            fwdValidVQ <= 1'b0;
            fwdDstSQ   <= '0;
            fwdDstVQ   <= '0;
            fwdDataQ   <= '0;
        end else begin
            fwdValidSQ <= commitS;
            fwdValidVQ <= commitV;
            if (commitS || commitV) begin
                fwdDstSQ <= dstS_i;
                fwdDstVQ <= dstV_i;
                fwdDataQ <= wbVal;
            end
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retiredQ <= '0;
        end else if (retire) begin
            retiredQ <= retiredQ + 32'd1;
        end
    end

    assign fwdValidS_o = fwdValidSQ;
    assign fwdValidV_o = fwdValidVQ;
    assign fwdDstS_o   = fwdDstSQ;
    assign fwdDstV_o   = fwdDstVQ;
    assign fwdData_o   = fwdDataQ;
    assign retired_o   = retiredQ;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a behavioural register-file model checked every cycle.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, memRd, wInt, wV;
    logic [63:0] intRd, aluRes;
    logic [3:0]  dstS, rsA, rsB;
    logic [1:0]  dstV, rvA, rvB;
    logic [31:0] rdA, rdB;
    logic [63:0] rvdA, rvdB;
    logic        fvS, fvV;
    logic [3:0]  fdS;
    logic [1:0]  fdV;
    logic [63:0] fData;
    logic [31:0] retired;

    int errCnt = 0;
    int chkCnt = 0;
    bit checking = 1'b0;

    // Model state
    logic [31:0] mS [16];
    logic [63:0] mV [4];
    logic        mFvS, mFvV;
    logic [3:0]  mFdS;
    logic [1:0]  mFdV;
    logic [63:0] mFData;
    logic [31:0] mCnt;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk_i(clk), .rst_i(rst), .enableReg_i(en), .flagMemRead_i(memRd),
        .writeResultInt_i(wInt), .writeResultV_i(wV), .int_rd_i(intRd), .alu_res_i(aluRes),
        .dstS_i(dstS), .dstV_i(dstV), .rsA_i(rsA), .rsB_i(rsB), .rvA_i(rvA), .rvB_i(rvB),
        .rdA_o(rdA), .rdB_o(rdB), .rvdA_o(rvdA), .rvdB_o(rvdB),
        .fwdValidS_o(fvS), .fwdValidV_o(fvV), .fwdDstS_o(fdS), .fwdDstV_o(fdV),
        .fwdData_o(fData), .retired_o(retired)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] selVal();
        return memRd ? intRd : aluRes;
    endfunction

    // Expected scalar read: r0 is zero, a same-cycle commit to the address wins.
    function automatic logic [31:0] expS(input logic [3:0] a);
        logic [63:0] v = selVal();
        if (a == 4'd0) return 32'd0;
        if (!rst && en && wInt && dstS == a) return v[31:0];
        return mS[a];
    endfunction

    function automatic logic [63:0] expV(input logic [1:0] a);
        if (!rst && en && wV && dstV == a) return selVal();
        return mV[a];
    endfunction

    // Model: apply the commit rules at every rising edge.
    always @(posedge clk) begin
        logic [63:0] v;
        logic cs, cv;
        if (rst) begin
            for (int i = 0; i < 16; i++) mS[i] = '0;
            for (int i = 0; i < 4; i++) mV[i] = '0;
            mFvS = 0; mFvV = 0; mFdS = 0; mFdV = 0; mFData = 0; mCnt = 0;
        end else begin
            v  = selVal();
            cs = en && wInt && dstS != 4'd0;
            cv = en && wV;
            if (cs) mS[dstS] = v[31:0];
            if (cv) mV[dstV] = v;
            mFvS = cs;
            mFvV = cv;
            if (cs || cv) begin
                mFdS = dstS; mFdV = dstV; mFData = v;
            end
            if (en && (wInt || wV)) mCnt = mCnt + 32'd1;
        end
    end

    // Compare all outputs against the model mid-cycle.
    always @(negedge clk) begin
        if (checking) begin
            chk("rdA", {32'd0, rdA}, {32'd0, expS(rsA)});
            chk("rdB", {32'd0, rdB}, {32'd0, expS(rsB)});
            chk("rvdA", rvdA, expV(rvA));
            chk("rvdB", rvdB, expV(rvB));
            chk("fwdValidS", {63'd0, fvS}, {63'd0, mFvS});
            chk("fwdValidV", {63'd0, fvV}, {63'd0, mFvV});
            chk("fwdDstS", {60'd0, fdS}, {60'd0, mFdS});
            chk("fwdDstV", {62'd0, fdV}, {62'd0, mFdV});
            chk("fwdData", fData, mFData);
            chk("retired", {32'd0, retired}, {32'd0, mCnt});
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic midCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        en = 0; wInt = 0; wV = 0; memRd = 0;
    endtask

    initial begin
        rst = 1; idle();
        intRd = '0; aluRes = '0; dstS = '0; dstV = '0;
        rsA = '0; rsB = '0; rvA = '0; rvB = '0;
        step(); step();
        rst = 0; checking = 1'b1;

        // Preload some state before exercising reset.
        en = 1; wInt = 1; dstS = 4'd7; aluRes = 64'h0000_0000_1234_5678;
        step();
        wInt = 0; wV = 1; dstV = 2'd0; aluRes = 64'hCAFE_F00D_0102_0304;
        step();
        idle(); rsA = 4'd7; rvA = 2'd0;
        midCycle();
        chk("preload_s7", {32'd0, rdA}, 64'h1234_5678);

        // 1: reset with a commit pending
        rst = 1; en = 1; wInt = 1; wV = 1; dstS = 4'd7; aluRes = 64'h5555_5555_5555_5555;
        step();
        rst = 0; idle();
        midCycle();
        chk("rst_rdA", {32'd0, rdA}, 64'd0);
        chk("rst_rvdA", rvdA, 64'd0);
        chk("rst_retired", {32'd0, retired}, 64'd0);
        chk("rst_fwdValidS", {63'd0, fvS}, 64'd0);

        // 2: scalar ALU commit
        en = 1; wInt = 1; memRd = 0; dstS = 4'd5; aluRes = 64'h1122_3344_AABB_CCDD;
        step();
        idle(); rsA = 4'd5;
        midCycle();
        chk("t2_rdA", {32'd0, rdA}, 64'hAABB_CCDD);
        chk("t2_fwdValidS", {63'd0, fvS}, 64'd1);
        chk("t2_fwdDstS", {60'd0, fdS}, 64'd5);
        chk("t2_retired", {32'd0, retired}, 64'd1);

        // 3: vector memory commit, visible through bypass in the same cycle
        step();
        en = 1; wV = 1; memRd = 1; dstV = 2'd2; intRd = 64'h0706_0504_0302_0100; rvA = 2'd2;
        midCycle();
        chk("t3_bypass_lane3", {56'd0, rvdA[31:24]}, 64'h03);
        chk("t3_bypass", rvdA, 64'h0706_0504_0302_0100);
        step();
        idle();
        midCycle();
        chk("t3_after", rvdA, 64'h0706_0504_0302_0100);

        // 4: r0 write dropped but counted, then a bubble with flags set
        step();
        en = 1; wInt = 1; dstS = 4'd0; aluRes = 64'h0000_0000_FFFF_FFFF; rsA = 4'd0;
        step();
        en = 0; wInt = 1; wV = 1;
        midCycle();
        chk("t4_r0", {32'd0, rdA}, 64'd0);
        chk("t4_retired", {32'd0, retired}, 64'd3);
        step();
        midCycle();
        chk("t4_bubble_fvS", {63'd0, fvS}, 64'd0);
        chk("t4_bubble_fvV", {63'd0, fvV}, 64'd0);
        chk("t4_bubble_cnt", {32'd0, retired}, 64'd3);

        // 5: dual commit counts once
        step();
        en = 1; wInt = 1; wV = 1; memRd = 0; dstS = 4'd3; dstV = 2'd1;
        aluRes = 64'hDEAD_BEEF_0000_0001; rsB = 4'd3; rvB = 2'd1;
        step();
        idle();
        midCycle();
        chk("t5_rdB", {32'd0, rdB}, 64'h1);
        chk("t5_rvdB", rvdB, 64'hDEAD_BEEF_0000_0001);
        chk("t5_retired", {32'd0, retired}, 64'd4);

        // Mixed traffic: every scalar address, vector addresses cycling, reads swept.
        for (int i = 0; i < 16; i++) begin
            step();
            en = (i % 5) != 4; memRd = i[0]; wInt = 1; wV = (i % 3) == 0;
            dstS = 4'(i); dstV = 2'(i); rsA = 4'(i); rsB = 4'(15 - i);
            rvA = 2'(i); rvB = 2'(i + 1);
            aluRes = {32'hA000_0000 + 32'(i), 32'h0B00_0000 + 32'(i * 17)};
            intRd  = {32'hC000_0000 + 32'(i), 32'h0D00_0000 + 32'(i * 29)};
        end
        step();
        idle();

        // 6: counter wrap
        step();
        force dut.retiredQ = 32'hFFFF_FFFF;
        #1;
        release dut.retiredQ;
        mCnt = 32'hFFFF_FFFF;
        en = 1; wInt = 1; dstS = 4'd4; aluRes = 64'h0000_0000_0000_0044;
        step();
        idle();
        midCycle();
        chk("t6_wrap", {32'd0, retired}, 64'd0);

        step(); step();
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
